// File: rtl/cla_sched_pkg.sv
// Shared types and constants for the serial carry-lookahead scheduler.
package cla_sched_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_nibble.sv
// Combinational 4-bit carry-lookahead slice. Besides sum and carry-out it
// exposes the carry into bit 3, which the scheduler uses for signed overflow.
module cla_nibble
  import cla_sched_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Flat lookahead equations: every carry is a function of g, p and cin only.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
  assign c3   = c[3];

endmodule

// File: rtl/cla_serial_sched.sv
// Two-requester round-robin scheduler sharing one 4-bit CLA slice. A granted
// add runs one nibble per cycle (LSB first) with the carry chained in a
// register, then the result is offered on a response handshake.
// Optional feature: define CLA_SCHED_OVF_EN to add the rsp_ovf output.
module cla_serial_sched
  import cla_sched_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout
`ifdef CLA_SCHED_OVF_EN
  ,
  output logic             rsp_ovf
`endif
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t               state_q, state_d;
  logic                 ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     a_q, b_q, sum_q;
  logic                 carry_q;
  logic                 id_q;
  logic                 gnt0, gnt1, accept, step, last;
  logic [NIBBLE_W-1:0]  nib_sum;
  logic                 nib_cout, nib_c3;

  assign last = (cnt_q == CNT_W'(NIB - 1));

  // Next-state, arbitration and datapath enables; ptr_q holds the last grant.
  always_comb begin
    state_d = state_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    accept  = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        gnt0   = req0_valid & (~req1_valid | ptr_q);
        gnt1   = req1_valid & (~req0_valid | ~ptr_q);
        accept = gnt0 | gnt1;
        if (accept) state_d = BUSY;
      end
      BUSY: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Readys are held low while reset is asserted.
  assign req0_ready = gnt0 & ~rst;
  assign req1_ready = gnt1 & ~rst;

  // FSM state register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Control and result registers: pointer, id, counter, carry chain, sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= 1'b1;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
    end else if (accept) begin
      ptr_q   <= gnt1;
      id_q    <= gnt1;
      cnt_q   <= '0;
      carry_q <= gnt1 ? req1_cin : req0_cin;
    end else if (step) begin
      cnt_q   <= cnt_q + 1'b1;
      carry_q <= nib_cout;
      // New nibble enters at the top; after NIB steps nibble 0 sits at the LSB.
      sum_q   <= (sum_q >> NIBBLE_W) | (WIDTH'(nib_sum) << (WIDTH - NIBBLE_W));
    end
  end

  // Operand shift registers feed the slice from their low nibble; no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= gnt1 ? req1_a : req0_a;
      b_q <= gnt1 ? req1_b : req0_b;
    end else if (step) begin
      a_q <= a_q >> NIBBLE_W;
      b_q <= b_q >> NIBBLE_W;
    end
  end

  cla_nibble u_nib (
    .a    (a_q[NIBBLE_W-1:0]),
    .b    (b_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout),
    .c3   (nib_c3)
  );

  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;

`ifdef CLA_SCHED_OVF_EN
  logic ovf_q;

  // Signed overflow from the final nibble: carry into MSB xor carry out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              ovf_q <= 1'b0;
    else if (step & last) ovf_q <= nib_c3 ^ nib_cout;
  end

  assign rsp_ovf = ovf_q;
`else
  logic unused_c3;
  assign unused_c3 = nib_c3;
`endif

endmodule

// File: tb/tb_cla_serial_sched.sv
// Directed self-checking bench for cla_serial_sched (64-bit and 4-bit builds).
module tb_cla_serial_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_cin;
  logic        req1_valid, req1_ready, req1_cin;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [63:0] rsp_sum;
  logic        r4_v0, r4_rdy0, r4_cin0, r4_v1, r4_rdy1, r4_cin1;
  logic [3:0]  r4_a0, r4_b0, r4_a1, r4_b1, r4_sum;
  logic        r4_rsp_valid, r4_rsp_ready, r4_id, r4_cout;
`ifdef CLA_SCHED_OVF_EN
  logic        rsp_ovf, r4_ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cla_serial_sched #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
`ifdef CLA_SCHED_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  cla_serial_sched #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(r4_v0), .req0_ready(r4_rdy0), .req0_a(r4_a0), .req0_b(r4_b0), .req0_cin(r4_cin0),
    .req1_valid(r4_v1), .req1_ready(r4_rdy1), .req1_a(r4_a1), .req1_b(r4_b1), .req1_cin(r4_cin1),
    .rsp_valid(r4_rsp_valid), .rsp_ready(r4_rsp_ready), .rsp_id(r4_id), .rsp_sum(r4_sum), .rsp_cout(r4_cout)
`ifdef CLA_SCHED_OVF_EN
    , .rsp_ovf(r4_ovf)
`endif
  );

  // Consumes the accept edge, then counts cycles until rsp_valid (bounded).
  task automatic wait_rsp(input bit clr, output int lat);
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (clr) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      if (rsp_valid) begin lat = i; break; end
    end
  endtask

  task automatic rsp_handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    r4_v0 = 1'b1; r4_v1 = 1'b0; r4_rsp_ready = 1'b0;
    r4_a0 = '0; r4_b0 = '0; r4_cin0 = 1'b0; r4_a1 = '0; r4_b1 = '0; r4_cin1 = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout} !== 5'b0)
      begin n_bad++; $display("FAIL reset_ctrl: got %b required 00000", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout}); end
    n_cmp++;
    if (rsp_sum !== 64'd0) begin n_bad++; $display("FAIL reset_sum: got %h required 0", rsp_sum); end
    n_cmp++;
    if ({r4_rdy0, r4_rsp_valid, r4_sum, r4_cout} !== 7'b0)
      begin n_bad++; $display("FAIL reset_w4: got %b required 0", {r4_rdy0, r4_rsp_valid, r4_sum, r4_cout}); end
`ifdef CLA_SCHED_OVF_EN
    n_cmp++;
    if (rsp_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b required 0", rsp_ovf); end
`endif
    req0_valid = 1'b0; req1_valid = 1'b0; r4_v0 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    req0_valid = 1'b1; req0_a = 64'hFFFF_FFFF_FFFF_FFFF; req0_b = 64'd1; req0_cin = 1'b0;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready: got %b required 1", req0_ready); end
    wait_rsp(1'b1, lat);
    n_cmp++;
    if (lat !== 17) begin n_bad++; $display("FAIL basic_latency: got %0d required 17", lat); end
    n_cmp++;
    if ({rsp_sum, rsp_cout, rsp_id} !== {64'd0, 1'b1, 1'b0})
      begin n_bad++; $display("FAIL basic_result: got sum=%h cout=%b id=%b required 0/1/0", rsp_sum, rsp_cout, rsp_id); end
`ifdef CLA_SCHED_OVF_EN
    n_cmp++;
    if (rsp_ovf !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %b required 0", rsp_ovf); end
`endif
    rsp_handshake();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL basic_release: got %b required 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    int lat;
    logic [63:0] exp_sum;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0_a = 64'h10; req0_b = 64'h20; req0_cin = 1'b0;
    req1_a = 64'h1111_0000_0000_0000; req1_b = 64'h2222_0000_0000_0001; req1_cin = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_sum = (i % 2 == 0) ? 64'h30 : 64'h3333_0000_0000_0002;
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        begin n_bad++; $display("FAIL rr_grant[%0d]: got %b%b required %s", i, req0_ready, req1_ready, (i % 2 == 0) ? "10" : "01"); end
      wait_rsp(i == 3, lat);
      n_cmp++;
      if (lat !== 17) begin n_bad++; $display("FAIL rr_latency[%0d]: got %0d required 17", i, lat); end
      n_cmp++;
      if ({rsp_id, rsp_sum} !== {1'(i % 2), exp_sum})
        begin n_bad++; $display("FAIL rr_result[%0d]: got id=%b sum=%h required id=%0d sum=%h", i, rsp_id, rsp_sum, i % 2, exp_sum); end
      if (i < 3) begin
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b00)
          begin n_bad++; $display("FAIL rr_done_ready[%0d]: got %b%b required 00", i, req0_ready, req1_ready); end
      end
      rsp_handshake();
    end
  endtask

  task automatic test_stall();
    int lat;
    req0_a = 64'd5; req0_b = 64'd6; req0_cin = 1'b0;
    req1_a = 64'h100; req1_b = 64'h200; req1_cin = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL stall_grant: got %b%b required 10", req0_ready, req1_ready); end
    wait_rsp(1'b0, lat);
    req0_valid = 1'b0;
    n_cmp++;
    if (lat !== 17) begin n_bad++; $display("FAIL stall_latency: got %0d required 17", lat); end
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_cout, req0_ready, req1_ready, rsp_sum} !== {5'b10000, 64'd11})
        begin n_bad++; $display("FAIL stall_hold[%0d]: got v=%b id=%b cout=%b rdy=%b%b sum=%h required 1/0/0/00/b", c, rsp_valid, rsp_id, rsp_cout, req0_ready, req1_ready, rsp_sum); end
    end
    @(negedge clk);
    rsp_handshake();
    #1;
    n_cmp++;
    if ({rsp_valid, req1_ready} !== 2'b01) begin n_bad++; $display("FAIL stall_next_accept: got v=%b rdy1=%b required 0/1", rsp_valid, req1_ready); end
    wait_rsp(1'b1, lat);
    n_cmp++;
    if ({lat == 17, rsp_id, rsp_sum} !== {1'b1, 1'b1, 64'h300})
      begin n_bad++; $display("FAIL stall_second: got lat=%0d id=%b sum=%h required 17/1/300", lat, rsp_id, rsp_sum); end
    rsp_handshake();
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    req0_valid = 1'b1; req0_a = 64'hFFFF_FFFF_FFFF_FFFF; req0_b = 64'd1; req0_cin = 1'b0;
    @(posedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) req0_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b000)
      begin n_bad++; $display("FAIL abort_immediate: got %b required 000", {rsp_valid, req0_ready, req1_ready}); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL abort_no_response: got %0d valid cycles required 0", seen); end
    req0_a = 64'h1234; req0_b = 64'h0F0F; req0_cin = 1'b1;
    req1_a = 64'd1; req1_b = 64'd1; req1_cin = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL abort_ptr_reset: got %b%b required 10", req0_ready, req1_ready); end
    wait_rsp(1'b0, lat);
    n_cmp++;
    if ({lat == 17, rsp_id, rsp_cout, rsp_sum} !== {3'b100, 64'h2144})
      begin n_bad++; $display("FAIL abort_next_op: got lat=%0d id=%b cout=%b sum=%h required 17/0/0/2144", lat, rsp_id, rsp_cout, rsp_sum); end
    rsp_handshake();
    #1;
    n_cmp++;
    if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL abort_req1_turn: got %b required 1", req1_ready); end
    wait_rsp(1'b1, lat);
    n_cmp++;
    if ({rsp_id, rsp_sum} !== {1'b1, 64'd2}) begin n_bad++; $display("FAIL abort_req1_result: got id=%b sum=%h required 1/2", rsp_id, rsp_sum); end
    rsp_handshake();
  endtask

  task automatic test_signed_edges();
    int lat;
    logic [63:0] va [2];
    logic [63:0] vb [2];
    logic [63:0] vs [2];
    logic        vc [2];
    va[0] = 64'h7FFF_FFFF_FFFF_FFFF; vb[0] = 64'd1; vs[0] = 64'h8000_0000_0000_0000; vc[0] = 1'b0;
    va[1] = 64'h8000_0000_0000_0000; vb[1] = 64'h8000_0000_0000_0000; vs[1] = 64'd0; vc[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req0_valid = 1'b1; req0_a = va[i]; req0_b = vb[i]; req0_cin = 1'b0;
      wait_rsp(1'b1, lat);
      n_cmp++;
      if ({lat == 17, rsp_sum, rsp_cout} !== {1'b1, vs[i], vc[i]})
        begin n_bad++; $display("FAIL edge_result[%0d]: got lat=%0d sum=%h cout=%b required 17/%h/%b", i, lat, rsp_sum, rsp_cout, vs[i], vc[i]); end
`ifdef CLA_SCHED_OVF_EN
      n_cmp++;
      if (rsp_ovf !== 1'b1) begin n_bad++; $display("FAIL edge_ovf[%0d]: got %b required 1", i, rsp_ovf); end
`endif
      rsp_handshake();
    end
  endtask

  task automatic test_width4();
    int lat;
    r4_v0 = 1'b1; r4_a0 = 4'h9; r4_b0 = 4'h8; r4_cin0 = 1'b1;
    #1;
    n_cmp++;
    if (r4_rdy0 !== 1'b1) begin n_bad++; $display("FAIL w4_ready: got %b required 1", r4_rdy0); end
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      r4_v0 = 1'b0;
      if (r4_rsp_valid) begin lat = i; break; end
    end
    n_cmp++;
    if (lat !== 2) begin n_bad++; $display("FAIL w4_latency: got %0d required 2", lat); end
    n_cmp++;
    if ({r4_sum, r4_cout, r4_id} !== {4'h2, 1'b1, 1'b0})
      begin n_bad++; $display("FAIL w4_result: got sum=%h cout=%b id=%b required 2/1/0", r4_sum, r4_cout, r4_id); end
`ifdef CLA_SCHED_OVF_EN
    n_cmp++;
    if (r4_ovf !== 1'b1) begin n_bad++; $display("FAIL w4_ovf: got %b required 1", r4_ovf); end
`endif
    r4_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r4_rsp_ready = 1'b0;
    n_cmp++;
    if (r4_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL w4_release: got %b required 0", r4_rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_stall();
    test_reset_abort();
    test_signed_edges();
    test_width4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
